// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline interlock: register file geometry,
// producer latency type and pipeline-register indices.
package pipe_pkg;

  localparam int NREG   = 32;
  localparam int AW     = $clog2(NREG);
  localparam int MAXLAT = 4;
  localparam int LATW   = $clog2(MAXLAT + 1);

  typedef logic [LATW-1:0] lat_t;
  typedef logic [AW-1:0]   reg_t;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWR = 3;

endpackage

// File: rtl/pipe_ctl_if.sv
// Decoder-side bundle for pipe_ctl: ID instruction info, EX status in,
// stall/flush/freeze enables, valid bits and perf counters out.
interface pipe_ctl_if import pipe_pkg::*; #(
  parameter int STAGES = 5,
  parameter int AW_P   = AW,
  parameter int LATW_P = LATW,
  parameter int CNTW   = 32
) ();

  logic              if_valid;
  logic              id_valid;
  logic [AW_P-1:0]   id_rs;
  logic [AW_P-1:0]   id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic              id_wr_en;
  logic [AW_P-1:0]   id_rd;
  logic [LATW_P-1:0] id_lat;
  logic              ex_busy;
  logic              br_taken;

  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_id;
  logic              freeze;
  logic [STAGES-1:0] stage_valid;
  logic [CNTW-1:0]   stall_cnt;
  logic [CNTW-1:0]   flush_cnt;

  modport master (
    output if_valid, id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
           id_wr_en, id_rd, id_lat, ex_busy, br_taken,
    input  stall_if, stall_id, bubble_ex, flush_id, freeze,
           stage_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_valid, id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
           id_wr_en, id_rd, id_lat, ex_busy, br_taken,
    output stall_if, stall_id, bubble_ex, flush_id, freeze,
           stage_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register countdown of cycles until a pending result becomes forwardable,
// with two read ports flagging "still more than one cycle away".
module pipe_scoreboard import pipe_pkg::*; #(
  parameter int NREG_P = NREG,
  parameter int AW_P   = AW,
  parameter int LATW_P = LATW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              issue_we,
  input  logic [AW_P-1:0]   wr_addr,
  input  logic [LATW_P-1:0] wr_lat,
  input  logic [AW_P-1:0]   rd_addr_a,
  input  logic [AW_P-1:0]   rd_addr_b,
  output logic              pend_a,
  output logic              pend_b
);

  logic [NREG_P-1:0][LATW_P-1:0] sb_reg;
  logic [NREG_P-1:0][LATW_P-1:0] sb_next;

  generate
    for (genvar gi = 0; gi < NREG_P; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign sb_next[gi] = '0;
      end else begin : g_reg
        logic [LATW_P-1:0] dec_next;
        logic              hit;
        assign dec_next = (sb_reg[gi] != '0) ? sb_reg[gi] - 1'b1 : '0;
        assign hit      = issue_we && (wr_addr == AW_P'(gi));
        // WAW: a newer writer never shortens the wait of an older one
        assign sb_next[gi] = hold ? sb_reg[gi] :
                             (hit && (wr_lat > dec_next)) ? wr_lat : dec_next;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  // sb == 1 forwards just in time for EX, so only >1 blocks issue
  assign pend_a = sb_reg[rd_addr_a] > LATW_P'(1);
  assign pend_b = sb_reg[rd_addr_b] > LATW_P'(1);

endmodule

// File: rtl/pipe_ctl.sv
// Scoreboard-driven interlock: stall/flush/freeze priority, per-stage valid
// shift register and saturating stall/flush counters.
module pipe_ctl import pipe_pkg::*; #(
  parameter int STAGES = 5,
  parameter int NREG   = pipe_pkg::NREG,
  parameter int AW     = pipe_pkg::AW,
  parameter int MAXLAT = pipe_pkg::MAXLAT,
  parameter int CNTW   = 32
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctl_if.slave  bus
);

  localparam int LATW_L = $clog2(MAXLAT + 1);

  logic pend_rs;
  logic pend_rt;
  logic raw;
  logic issue;

  logic stall_if_w;
  logic stall_id_w;
  logic bubble_ex_w;
  logic flush_id_w;
  logic freeze_w;

  logic [STAGES-1:0] sv_reg;
  logic [STAGES-1:0] sv_next;
  logic [CNTW-1:0]   stall_cnt_reg;
  logic [CNTW-1:0]   flush_cnt_reg;

  pipe_scoreboard #(
    .NREG_P (NREG),
    .AW_P   (AW),
    .LATW_P (LATW_L)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .hold      (bus.ex_busy),
    .issue_we  (issue && bus.id_wr_en && (bus.id_rd != '0)),
    .wr_addr   (bus.id_rd),
    .wr_lat    (bus.id_lat),
    .rd_addr_a (bus.id_rs),
    .rd_addr_b (bus.id_rt),
    .pend_a    (pend_rs),
    .pend_b    (pend_rt)
  );

  assign raw = bus.id_valid &&
               ((bus.id_rs_use && (bus.id_rs != '0) && pend_rs) ||
                (bus.id_rt_use && (bus.id_rt != '0) && pend_rt));

  assign issue = bus.id_valid && !raw && !bus.br_taken && !bus.ex_busy;

  always_comb begin
    stall_if_w  = 1'b0;
    stall_id_w  = 1'b0;
    bubble_ex_w = 1'b0;
    flush_id_w  = 1'b0;
    freeze_w    = 1'b0;
    if (!reset) begin
      if (bus.br_taken) begin
        flush_id_w  = 1'b1;
        bubble_ex_w = 1'b1;
      end else if (bus.ex_busy) begin
        freeze_w   = 1'b1;
        stall_if_w = 1'b1;
        stall_id_w = 1'b1;
      end else if (raw) begin
        stall_if_w  = 1'b1;
        stall_id_w  = 1'b1;
        bubble_ex_w = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_sv
      if (gi == IFID) begin : g_ifid
        assign sv_next[gi] = stall_id_w ? sv_reg[gi] : (bus.if_valid && !bus.br_taken);
      end else if (gi == IDEX) begin : g_idex
        assign sv_next[gi] = issue;
      end else begin : g_shift
        assign sv_next[gi] = sv_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_reg <= '0;
    end else if (!freeze_w) begin
      sv_reg <= sv_next;
    end
  end

  // Stall cycles are the ones where IF/ID is actually held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_id_w && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (bus.br_taken && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.stall_if    = stall_if_w;
  assign bus.stall_id    = stall_id_w;
  assign bus.bubble_ex   = bubble_ex_w;
  assign bus.flush_id    = flush_id_w;
  assign bus.freeze      = freeze_w;
  assign bus.stage_valid = sv_reg;
  assign bus.stall_cnt   = stall_cnt_reg;
  assign bus.flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: each vector queues its expected outputs and a
// negedge monitor pops and compares them against what the DUT presents.
module tb_pipe_ctl;
  import pipe_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pipe_ctl_if #(.STAGES(5), .AW_P(AW), .LATW_P(LATW), .CNTW(4)) bus ();

  pipe_ctl #(
    .STAGES (5),
    .NREG   (NREG),
    .AW     (AW),
    .MAXLAT (MAXLAT),
    .CNTW   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // m: bit0 check stage_valid, bit1 check stall_cnt, bit2 check flush_cnt
  typedef struct {
    int         id;
    logic [4:0] ctl;
    logic [4:0] sv;
    logic [3:0] sc;
    logic [3:0] fc;
    logic [2:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input int id, input string nm, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s: got %b want %b", id, nm, got, want);
    end
  endtask

  task automatic step(input int id, input logic rst_v, input logic ifv, input logic idv,
                      input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                      input logic wr, input logic [4:0] rd, input logic [2:0] lat,
                      input logic busy, input logic br,
                      input logic [4:0] ctl, input logic [4:0] sv,
                      input logic [3:0] sc, input logic [3:0] fc, input logic [2:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst_v;
    bus.if_valid  = ifv;
    bus.id_valid  = idv;
    bus.id_rs     = rs;
    bus.id_rs_use = rsu;
    bus.id_rt     = rt;
    bus.id_rt_use = rtu;
    bus.id_wr_en  = wr;
    bus.id_rd     = rd;
    bus.id_lat    = lat;
    bus.ex_busy   = busy;
    bus.br_taken  = br;
    e.id  = id;
    e.ctl = ctl;
    e.sv  = sv;
    e.sc  = sc;
    e.fc  = fc;
    e.m   = m;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [4:0] ctl_now;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      ctl_now = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id, bus.freeze};
      $display("v%0d ctl=%b sv=%b scnt=%0d fcnt=%0d", e.id, ctl_now, bus.stage_valid,
               bus.stall_cnt, bus.flush_cnt);
      chk(e.id, "ctl", ctl_now, e.ctl);
      if (e.m[0]) chk(e.id, "stage_valid", bus.stage_valid, e.sv);
      if (e.m[1]) chk(e.id, "stall_cnt", {1'b0, bus.stall_cnt}, {1'b0, e.sc});
      if (e.m[2]) chk(e.id, "flush_cnt", {1'b0, bus.flush_cnt}, {1'b0, e.fc});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(bus.br_taken && bus.ex_busy))
        else $error("br_taken and ex_busy both high");
    end
  end

  initial begin
    bus.if_valid  = 1'b0;
    bus.id_valid  = 1'b0;
    bus.id_rs     = '0;
    bus.id_rs_use = 1'b0;
    bus.id_rt     = '0;
    bus.id_rt_use = 1'b0;
    bus.id_wr_en  = 1'b0;
    bus.id_rd     = '0;
    bus.id_lat    = 3'd1;
    bus.ex_busy   = 1'b0;
    bus.br_taken  = 1'b0;

    //   id rst ifv idv  rs rsu rt rtu  wr rd lat  busy br   ctl       sv       sc fc m
    step( 0, 1, 1, 0,   0, 0, 0, 0,   0, 0, 1,   1, 0,  5'b00000, 5'b00000, 0, 0, 7);
    step( 1, 0, 1, 0,   0, 0, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b00000, 0, 0, 7);
    // ADD r3 lat 1 then reader: no stall
    step( 2, 0, 1, 1,   0, 0, 0, 0,   1, 3, 1,   0, 0,  5'b00000, 5'b00001, 0, 0, 7);
    step( 3, 0, 1, 1,   3, 1, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b00011, 0, 0, 7);
    // LW r5 lat 2 then reader: one bubble
    step( 4, 0, 1, 1,   3, 1, 0, 0,   1, 5, 2,   0, 0,  5'b00000, 5'b00111, 0, 0, 7);
    step( 5, 0, 1, 1,   0, 0, 5, 1,   0, 0, 1,   0, 0,  5'b11100, 5'b01111, 0, 0, 7);
    step( 6, 0, 1, 1,   0, 0, 5, 1,   0, 0, 1,   0, 0,  5'b00000, 5'b11101, 1, 0, 7);
    // r0 write lat 4 then r0 read: never stalls
    step( 7, 0, 1, 1,   0, 0, 0, 0,   1, 0, 4,   0, 0,  5'b00000, 5'b11011, 1, 0, 7);
    step( 8, 0, 1, 1,   0, 1, 0, 1,   0, 0, 1,   0, 0,  5'b00000, 5'b10111, 1, 0, 7);
    // hazard on r9 meets a taken branch; the flushed writer of r10 must not land
    step( 9, 0, 1, 1,   0, 0, 0, 0,   1, 9, 3,   0, 0,  5'b00000, 5'b01111, 1, 0, 7);
    step(10, 0, 1, 1,   9, 1, 0, 0,   1,10, 4,   0, 1,  5'b00110, 5'b11111, 1, 0, 7);
    step(11, 0, 1, 0,   0, 0, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b11100, 0, 1, 5);
    step(12, 0, 1, 1,  10, 1, 9, 1,   0, 0, 1,   0, 0,  5'b00000, 5'b11001, 0, 1, 5);
    // r7 lat 4, three frozen cycles, then exactly three stalls
    step(13, 0, 1, 1,   0, 0, 0, 0,   1, 7, 4,   0, 0,  5'b00000, 5'b10011, 0, 1, 5);
    for (int i = 14; i <= 16; i++)
      step(i, 0, 1, 1,  7, 1, 0, 0,   0, 0, 1,   1, 0,  5'b11001, 5'b00111, 0, 1, 5);
    step(17, 0, 1, 1,   7, 1, 0, 0,   0, 0, 1,   0, 0,  5'b11100, 5'b00111, 0, 1, 5);
    step(18, 0, 1, 1,   7, 1, 0, 0,   0, 0, 1,   0, 0,  5'b11100, 5'b01101, 0, 1, 5);
    step(19, 0, 1, 1,   7, 1, 0, 0,   0, 0, 1,   0, 0,  5'b11100, 5'b11001, 0, 1, 5);
    step(20, 0, 1, 1,   7, 1, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b10001, 0, 1, 5);
    // drive stall_cnt into saturation with freeze cycles
    for (int i = 21; i <= 32; i++)
      step(i, 0, 1, 0,  0, 0, 0, 0,   0, 0, 1,   1, 0,  5'b11001, 5'b00011, 0, 1, 5);
    for (int i = 33; i <= 34; i++)
      step(i, 0, 1, 0,  0, 0, 0, 0,   0, 0, 1,   1, 0,  5'b11001, 5'b00011,15, 1, 7);
    // reset in the middle of a load-use stall
    step(35, 0, 1, 1,   0, 0, 0, 0,   1, 5, 3,   0, 0,  5'b00000, 5'b00011,15, 1, 7);
    step(36, 0, 1, 1,   5, 1, 0, 0,   0, 0, 1,   0, 0,  5'b11100, 5'b00111,15, 1, 7);
    step(37, 1, 1, 1,   5, 1, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b00000, 0, 0, 7);
    step(38, 0, 1, 1,   5, 1, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b00000, 0, 0, 7);
    step(39, 0, 1, 0,   0, 0, 0, 0,   0, 0, 1,   0, 0,  5'b00000, 5'b00011, 0, 0, 7);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
# pipe_ctl

Parametrised pipeline control for the MIPS core: generalises the fixed one-cycle hazard stall and the forwarding-select logic into a scoreboard-driven interlock. It works for N stages, variable producer latencies (ALU, load, multi-cycle units), taken-branch flushes and whole-pipe freezes from a busy execution unit. It sits beside the IF/ID decoder and drives the stall and flush enables of the IFU and pipeline registers. It also tracks per-stage valid bits and saturating performance counters.

## Interface
- STAGES, 5: number of pipeline registers tracked, IF/ID = bit 0.
- NREG, 32: architectural registers; register 0 is never tracked.
- AW, 5: register address width, equal to $clog2(NREG).
- MAXLAT, 4: largest producer latency accepted on id_lat.
- CNTW, 32: performance counter width.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  IFU presents a real instruction this cycle.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs, id_rt  in  AW each  source register addresses of the ID instruction.
- id_rs_use, id_rt_use  in  1 each  the source is actually read.
- id_wr_en  in  1  the ID instruction writes a register.
- id_rd  in  AW  destination register.
- id_lat  in  $clog2(MAXLAT+1)  cycles until the result is forwardable; range 1..MAXLAT.
- ex_busy  in  1  multi-cycle EX unit is not done; the whole pipe freezes.
- br_taken  in  1  branch or jump resolved taken in EX this cycle.
- stall_if, stall_id  out  1  hold the PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  clear IF/ID.
- freeze  out  1  hold every pipeline register, including EX and later.
- stage_valid  out  STAGES  valid bit per pipeline register.
- stall_cnt, flush_cnt  out  CNTW each  saturating counts of stall cycles and taken flushes.

## Operation
- Scoreboard: one counter per register, sb[r], range 0..MAXLAT. sb[r] = k means the value is forwardable in k cycles.
- RAW hazard: id_valid & ((id_rs_use & id_rs≠0 & sb[id_rs]>1) | (id_rt_use & id_rt≠0 & sb[id_rt]>1)).
  - sb = 1 means the value is forwardable exactly when the consumer enters EX, so no stall.
- Issue condition: id_valid & ~raw & ~br_taken & ~ex_busy.
  - On issue with id_wr_en & id_rd≠0: sb[id_rd] <= max(sb[id_rd]-1, id_lat). This resolves WAW by taking the later of the two.
- Decrement: every cycle without ex_busy, every nonzero sb decrements. For the issued register, the issue write overrides the decrement.
- Output priority, highest first:
  1. reset: all outputs 0.
  2. br_taken: flush_id=1, bubble_ex=1, no stalls, no issue.
  3. ex_busy: freeze=stall_if=stall_id=1, no decrement, stage_valid held.
  4. raw: stall_if=stall_id=bubble_ex=1.
- stage_valid update, when not frozen:
  - bit0 <= if_valid & ~br_taken when IF/ID is not stalled; otherwise bit0 is held.
  - bit1 <= issue.
  - bit i <= bit i-1 for i≥2.
- br_taken with ex_busy both high is illegal; verification asserts it never occurs.
- stall_cnt increments on each raw or ex_busy cycle. flush_cnt increments on each br_taken cycle. Both saturate at all-ones.

## Timing
- Reset (asynchronous) clears sb, stage_valid and both counters. All stall, flush and freeze outputs are forced 0 while reset is high.
- Stall, flush and freeze outputs are combinational from inputs and sb in the same cycle. sb and stage_valid update on the rising edge.
- Load-use (id_lat=2) followed immediately by a consumer: exactly one bubble. Latency L: L-1 bubbles.
- Reset mid-stall: the stall drops immediately and the scoreboard is empty after release.

## Structure
- Shared package pipe_pkg: AW/NREG constants, the latency type, and the stage index constants (IFID=0, IDEX=1, EXMEM=2, MEMWR=3).
- Sub-module pipe_scoreboard: sb array, issue and decrement logic, and two read ports returning a "pending>1" flag. pipe_ctl holds the priority logic, valid shift register and counters.

## Test plan
- Issue ADD r3 (lat 1), then the next cycle an instruction reading r3 → no stall; stall_cnt stays 0.
- Issue LW r5 (lat 2), then next cycle a reader of r5 → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; stall_cnt=1.
- Write r0 with lat 4, then read r0 → never stalls; sb[0] stays 0.
- Hazard pending while br_taken=1 → flush_id=1, no stall, stage_valid[0] cleared next cycle, flush_cnt=1, no scoreboard write.
- Issue lat 4 to r7, hold ex_busy 3 cycles → sb[7] stays 4 during freeze. A consumer then stalls for exactly 3 unfrozen cycles.
- Preload counters to all-ones minus 1 via repeated stalls with CNTW=4 → the counter saturates at 15. Asserting reset mid-stall clears all outputs immediately.
